// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC and the IF/ID register, fetching over a one-outstanding req/ack imem port.
// Optional performance counters are built when IFU_PERF_CNT_EN is defined.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ID_stall,
  input  logic        ID_PCSrc,
  input  logic [31:0] ID_new_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_valid,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_squash_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP, S_FULL} state_t;

  state_t      state_p0, state_nxt;
  logic [31:0] pc_p0, pc_nxt;
  logic [31:0] pending_pc_p0, pending_pc_nxt;
  logic [31:0] buf_instr_p0, buf_instr_nxt;
  logic [31:0] buf_pc4_p0, buf_pc4_nxt;
  logic [31:0] ifid_instr_nxt, ifid_pc4_nxt;
  logic        ifid_vld_nxt;
  logic        redirect;
  logic [31:0] redirect_pc, pc_plus4;

  assign redirect    = ID_PCSrc & ~ID_stall;
  assign redirect_pc = ID_new_PC & ~32'd3;
  assign pc_plus4    = pc_p0 + 32'd4;

  // The in-flight address is always the PC: it only moves once an ack retires the fetch.
  assign imem_req  = (state_p0 == S_FETCH) || (state_p0 == S_DROP);
  assign imem_addr = pc_p0;

  always_comb begin
    state_nxt      = state_p0;
    pc_nxt         = pc_p0;
    pending_pc_nxt = pending_pc_p0;
    buf_instr_nxt  = buf_instr_p0;
    buf_pc4_nxt    = buf_pc4_p0;
    ifid_instr_nxt = IF_ID_Instruction;
    ifid_pc4_nxt   = IF_ID_PC4;
    ifid_vld_nxt   = IF_ID_valid;
    if (!ID_stall) begin
      ifid_instr_nxt = NOP_WORD;
      ifid_vld_nxt   = 1'b0;
    end
    case (state_p0)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_nxt = redirect_pc;
          end else if (!ID_stall) begin
            ifid_instr_nxt = imem_rdata;
            ifid_pc4_nxt   = pc_plus4;
            ifid_vld_nxt   = 1'b1;
            pc_nxt         = pc_plus4;
          end else begin
            buf_instr_nxt = imem_rdata;
            buf_pc4_nxt   = pc_plus4;
            pc_nxt        = pc_plus4;
            state_nxt     = S_FULL;
          end
        end else if (redirect) begin
          pending_pc_nxt = redirect_pc;
          state_nxt      = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect) pending_pc_nxt = redirect_pc;
        if (imem_ack) begin
          pc_nxt    = redirect ? redirect_pc : pending_pc_p0;
          state_nxt = S_FETCH;
        end
      end
      S_FULL: begin
        if (redirect) begin
          pc_nxt    = redirect_pc;
          state_nxt = S_FETCH;
        end else if (!ID_stall) begin
          ifid_instr_nxt = buf_instr_p0;
          ifid_pc4_nxt   = buf_pc4_p0;
          ifid_vld_nxt   = 1'b1;
          state_nxt      = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: control state, PC and IF/ID register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_p0          <= S_IDLE;
      pc_p0             <= RESET_PC;
      IF_ID_Instruction <= NOP_WORD;
      IF_ID_PC4         <= 32'd0;
      IF_ID_valid       <= 1'b0;
    end else begin
      state_p0          <= state_nxt;
      pc_p0             <= pc_nxt;
      IF_ID_Instruction <= ifid_instr_nxt;
      IF_ID_PC4         <= ifid_pc4_nxt;
      IF_ID_valid       <= ifid_vld_nxt;
    end
  end

  // Stage p0 data side: skid buffer and pending target are only read when the state says they are live
  always_ff @(posedge Clk) begin
    pending_pc_p0 <= pending_pc_nxt;
    buf_instr_p0  <= buf_instr_nxt;
    buf_pc4_p0    <= buf_pc4_nxt;
  end

`ifdef IFU_PERF_CNT_EN
  logic        fetch_inc, squash_inc;
  logic [31:0] fetch_cnt_p0, squash_cnt_p0;

  assign fetch_inc  = ~ID_stall & ifid_vld_nxt;
  assign squash_inc = ((state_p0 == S_FETCH) & imem_ack & redirect) |
                      ((state_p0 == S_DROP) & imem_ack) |
                      ((state_p0 == S_FULL) & redirect);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      fetch_cnt_p0  <= 32'd0;
      squash_cnt_p0 <= 32'd0;
    end else begin
      if (fetch_inc)  fetch_cnt_p0  <= fetch_cnt_p0 + 32'd1;
      if (squash_inc) squash_cnt_p0 <= squash_cnt_p0 + 32'd1;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_p0;
  assign perf_squash_cnt = squash_cnt_p0;
`else
  assign perf_fetch_cnt  = 32'd0;
  assign perf_squash_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based reference model.
module tb_instruction_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ID_stall = 1'b0;
  logic        ID_PCSrc = 1'b0;
  logic [31:0] ID_new_PC = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_valid;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_squash_cnt;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ID_stall(ID_stall), .ID_PCSrc(ID_PCSrc), .ID_new_PC(ID_new_PC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC4(IF_ID_PC4), .IF_ID_valid(IF_ID_valid),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_squash_cnt(perf_squash_cnt)
  );

  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: fetch progress, a wrong-path flag, and a queue holding at most one parked word.
  bit          m_started, m_wrong, m_vld;
  logic [31:0] m_pc, m_pending, m_instr, m_pc4;
  logic [63:0] m_held[$];
  logic [31:0] m_fetch, m_squash;

  task automatic model_reset();
    m_started = 0; m_wrong = 0; m_held.delete();
    m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_vld = 0;
    m_fetch = 32'd0; m_squash = 32'd0;
  endtask

  task automatic model_step();
    bit rd;
    logic [31:0] tgt;
    rd  = ID_PCSrc && !ID_stall;
    tgt = ID_new_PC & 32'hFFFF_FFFC;
    if (!ID_stall) begin m_instr = NOP; m_vld = 0; end
    if (!m_started) begin
      m_started = 1;
    end else if (m_held.size() != 0) begin
      if (rd) begin m_held.delete(); m_pc = tgt; m_squash++; end
      else if (!ID_stall) begin {m_instr, m_pc4} = m_held.pop_front(); m_vld = 1; m_fetch++; end
    end else if (m_wrong) begin
      if (rd) m_pending = tgt;
      if (imem_ack) begin m_pc = m_pending; m_wrong = 0; m_squash++; end
    end else if (imem_ack) begin
      if (rd) begin m_pc = tgt; m_squash++; end
      else if (!ID_stall) begin
        m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_vld = 1; m_pc = m_pc + 32'd4; m_fetch++;
      end else begin
        m_held.push_back({imem_rdata, m_pc + 32'd4}); m_pc = m_pc + 32'd4;
      end
    end else if (rd) begin
      m_pending = tgt; m_wrong = 1;
    end
  endtask

  function automatic logic [31:0] exp_cnt(input logic [31:0] c);
`ifdef IFU_PERF_CNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    bit exp_req;
    forever begin
      @(negedge Clk);
      exp_req = m_started && (m_held.size() == 0);
      chk("m_instr", IF_ID_Instruction, m_instr);
      chk("m_pc4", IF_ID_PC4, m_pc4);
      chk("m_valid", 32'(IF_ID_valid), 32'(m_vld));
      chk("m_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("m_addr", imem_addr, m_pc);
      chk("m_fetch_cnt", perf_fetch_cnt, exp_cnt(m_fetch));
      chk("m_squash_cnt", perf_squash_cnt, exp_cnt(m_squash));
    end
  end

  // One clock: inputs driven now (at a falling edge), model advanced at the rising edge.
  task automatic cyc(input bit ack, input bit st, input bit ps, input logic [31:0] np,
                     input logic [31:0] rd);
    imem_ack = ack; ID_stall = st; ID_PCSrc = ps; ID_new_PC = np; imem_rdata = rd;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  initial begin
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    chk("rst_instr", IF_ID_Instruction, NOP);
    chk("rst_pc4", IF_ID_PC4, 32'd0);
    chk("rst_valid", 32'(IF_ID_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_fetch_cnt", perf_fetch_cnt, 32'd0);
    Rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", imem_addr, 32'd0);
    cyc(1, 0, 0, 0, imem_addr);
    chk("seq_pc4_a", IF_ID_PC4, 32'd4);
    chk("seq_valid", 32'(IF_ID_valid), 32'd1);
    chk("seq_addr_a", imem_addr, 32'd4);
    cyc(1, 0, 0, 0, imem_addr);
    chk("seq_pc4_b", IF_ID_PC4, 32'd8);
    chk("seq_instr_b", IF_ID_Instruction, 32'd4);
    chk("seq_addr_b", imem_addr, 32'd8);
    // ack at PC=8 while decode stalls for three cycles
    cyc(1, 1, 0, 0, imem_addr);
    chk("stall_pc4", IF_ID_PC4, 32'd8);
    chk("stall_req", 32'(imem_req), 32'd0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("stall_instr", IF_ID_Instruction, 32'd4);
    chk("stall_req_3", 32'(imem_req), 32'd0);
    cyc(0, 0, 0, 0, 0);
    chk("unstall_pc4", IF_ID_PC4, 32'd12);
    chk("unstall_instr", IF_ID_Instruction, 32'd8);
    chk("unstall_addr", imem_addr, 32'd12);
    cyc(1, 0, 0, 0, imem_addr);
    chk("after_pc4", IF_ID_PC4, 32'd16);
    // redirect with a same-cycle ack
    cyc(1, 0, 1, 32'h100, imem_addr);
    chk("redir_valid", 32'(IF_ID_valid), 32'd0);
    chk("redir_instr", IF_ID_Instruction, 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_squash", perf_squash_cnt, exp_cnt(32'd1));
    chk("redir_fetch", perf_fetch_cnt, exp_cnt(32'd4));
    cyc(1, 0, 0, 0, imem_addr);
    chk("tgt_pc4", IF_ID_PC4, 32'h104);
    // redirect while the ack is late; the second target wins
    cyc(0, 0, 1, 32'h300, 0);
    chk("drop_addr_a", imem_addr, 32'h104);
    chk("drop_req", 32'(imem_req), 32'd1);
    cyc(0, 0, 1, 32'h200, 0);
    chk("drop_addr_b", imem_addr, 32'h104);
    cyc(0, 0, 0, 0, 0);
    chk("drop_addr_c", imem_addr, 32'h104);
    cyc(1, 0, 0, 0, 32'hDEAD_BEEF);
    chk("drop_new_addr", imem_addr, 32'h200);
    chk("drop_valid", 32'(IF_ID_valid), 32'd0);
    cyc(1, 0, 0, 0, imem_addr);
    chk("drop_tgt_pc4", IF_ID_PC4, 32'h204);
    // PCSrc under stall is ignored
    cyc(0, 1, 1, 32'h400, 0);
    chk("stall_redir_addr", imem_addr, 32'h204);
    chk("stall_redir_pc4", IF_ID_PC4, 32'h204);
    chk("stall_redir_valid", 32'(IF_ID_valid), 32'd1);
    // unaligned target is forced aligned, then PC wraps
    cyc(1, 0, 1, 32'hFFFF_FFFF, imem_addr);
    chk("align_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, imem_addr);
    chk("wrap_pc4", IF_ID_PC4, 32'd0);
    chk("wrap_instr", IF_ID_Instruction, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'd0);
    // async reset while waiting on a wrong-path ack
    cyc(0, 0, 1, 32'h500, 0);
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_req", 32'(imem_req), 32'd0);
    chk("arst_valid", 32'(IF_ID_valid), 32'd0);
    chk("arst_pc4", IF_ID_PC4, 32'd0);
    chk("arst_instr", IF_ID_Instruction, NOP);
    @(negedge Clk);
    ID_PCSrc = 1'b0;
    Rst_n = 1'b1;
    cyc(1, 0, 0, 0, 32'h1234_5678);
    chk("arst_first_req", 32'(imem_req), 32'd1);
    chk("arst_first_addr", imem_addr, 32'd0);
    chk("arst_first_valid", 32'(IF_ID_valid), 32'd0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(imem_req && ($urandom_range(0, 1) == 1),
          $urandom_range(0, 9) < 3,
          $urandom_range(0, 9) < 2,
          $urandom,
          $urandom);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- IF stage directly upstream of instruction decode.
- Owns the PC and the IF/ID pipeline register (IF_ID_Instruction, IF_ID_PC4).
- Talks to a variable-latency instruction memory through a req/ack handshake with one request outstanding.
- Consumes ID_stall, ID_PCSrc and ID_new_PC from decode. No branch delay slot: a taken redirect squashes the wrong-path fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID as a bubble.

Ports:
- Clk  input  1  clock, all state on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- ID_stall  input  1  decode cannot accept a new instruction; IF/ID must hold.
- ID_PCSrc  input  1  decode redirect (taken branch or jump).
- ID_new_PC  input  32  redirect target.
- imem_req  output  1  fetch request.
- imem_addr  output  32  word-aligned fetch address; stable while imem_req=1 and no ack.
- imem_ack  input  1  response valid this cycle; may arrive in the same cycle as the request.
- imem_rdata  input  32  instruction word, valid with imem_ack.
- IF_ID_Instruction  output  32  registered instruction to decode.
- IF_ID_PC4  output  32  registered PC+4 of that instruction.
- IF_ID_valid  output  1  1 = real instruction, 0 = bubble.
- perf_fetch_cnt  output  32  see Optional Feature.
- perf_squash_cnt  output  32  see Optional Feature.

Behaviour:
- Redirect = ID_PCSrc & ~ID_stall. ID_PCSrc is ignored while ID_stall=1.
- Reset (async, Rst_n=0):
  - state=S_IDLE, PC=RESET_PC, buffer empty.
  - IF_ID_Instruction=NOP_WORD, IF_ID_PC4=0, IF_ID_valid=0, imem_req=0, counters=0.
- imem_req=1 in S_FETCH and S_DROP only. imem_addr=PC, or the held address in S_DROP.
- IF/ID update rule: ID_stall=1 → hold all IF/ID regs. Otherwise load from the source given by the state transitions, or a bubble (NOP_WORD, PC4 unchanged, valid=0) when there is no source.
- S_IDLE: next cycle → S_FETCH.
- S_FETCH, ack & redirect: discard rdata; PC←ID_new_PC; IF/ID←bubble; stay S_FETCH; squash++.
- S_FETCH, ack & ~ID_stall: IF/ID←{rdata, PC+4, valid=1}; PC←PC+4; stay S_FETCH; fetch++.
- S_FETCH, ack & ID_stall: buffer←{rdata, PC+4}; PC←PC+4; → S_FULL.
- S_FETCH, ~ack & redirect: pending_pc←ID_new_PC; IF/ID←bubble; → S_DROP.
- S_FETCH, ~ack & ~redirect & ~ID_stall: IF/ID←bubble.
- S_DROP: keep req with old address until ack. On ack: discard rdata; PC←pending_pc; squash++; → S_FETCH.
- S_DROP, further redirect while waiting: overwrite pending_pc (latest redirect wins).
- S_FULL: imem_req=0.
  - redirect: discard buffer; PC←ID_new_PC; IF/ID←bubble; squash++; → S_FETCH.
  - ~ID_stall: IF/ID←buffer with valid=1; fetch++; → S_FETCH.
- Latency: 1-cycle imem ack gives one instruction per cycle into IF/ID, issued the cycle after ack.
- PC arithmetic is 32-bit and wraps at 32'hFFFF_FFFC → 0. Bits [1:0] of ID_new_PC are forced to 0.
- Reset asserted mid-request: state clears immediately. A late ack after reset is ignored, because S_IDLE does not sample ack.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined: perf_fetch_cnt counts instructions delivered into IF/ID with valid=1. perf_squash_cnt counts discarded fetches and buffers. Both are 32-bit, wrap, and reset to 0.
- Undefined: no counter flops; both outputs tied to 0.

Test Plan:
- Reset release, imem_ack=1 every cycle, rdata=addr → IF_ID_PC4 = 4, 8, 12… on consecutive cycles; IF_ID_valid=1 from the 3rd cycle after reset release; imem_addr = 0, 4, 8.
- ID_stall=1 for 3 cycles with an ack at PC=8 → IF/ID frozen; state S_FULL; imem_req=0. Stall drop → IF_ID_PC4=12, then the next fetch issues at addr 12. No instruction lost or duplicated.
- ID_PCSrc=1, ID_new_PC=32'h100 with same-cycle ack → next IF/ID is a bubble (valid=0, instr=0); imem_addr=32'h100 next cycle; squash count +1.
- Redirect while ack is delayed 3 cycles → imem_addr holds the old value until ack, that data is discarded, then imem_addr=target. A second redirect during the wait (target 32'h200) wins.
- ID_PCSrc=1 together with ID_stall=1 → no redirect; PC and IF/ID unchanged.
- Rst_n pulsed low while in S_DROP → all outputs return to reset values asynchronously; first post-reset imem_addr=RESET_PC.
